// File: rtl/regfile_writeback_pkg.sv
// Shared pipeline definitions for register-file writeback: widths, result bundle, source select.
package regfile_writeback_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN_DEF   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t           rd;
        logic [XLEN_DEF-1:0] data;
    } wb_result_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

    // One-hot register mask; x0 never produces a bit.
    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t a);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (a != '0) begin
            m[a] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_writeback_result_fifo.sv
// Synchronous FIFO with occupancy count; push at full is accepted when a pop occurs in the same cycle.
module result_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = wb_result_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  T                         i_push_data,
    input  logic                     i_pop,
    output T                         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_full;
    logic           w_empty;
    logic           w_do_push;
    logic           w_do_pop;

    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == '0);
        w_do_pop  = i_pop & ~w_empty;
        w_do_push = i_push & (~w_full | w_do_pop);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port driver: merges ALU and long-latency results, tracks busy destinations.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic                    ll_valid,
    output logic                    ll_ready,
    input  logic [REG_ADDR_W-1:0]   ll_rd,
    input  logic [XLEN-1:0]         ll_data,
    input  logic                    iss_valid,
    input  logic [REG_ADDR_W-1:0]   iss_rd,
    output logic [REG_ADDR_W-1:0]   rd,
    output logic [XLEN-1:0]         writedata,
    output logic                    regwrite,
    output logic [NUM_REGS-1:0]     busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } ll_entry_t;

    ll_entry_t               w_push_data;
    ll_entry_t               w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;

    wb_src_e                 w_src;
    logic [REG_ADDR_W-1:0]   w_sel_rd;
    logic [XLEN-1:0]         w_sel_data;
    logic [NUM_REGS-1:0]     w_set_mask;
    logic [NUM_REGS-1:0]     w_clr_mask;

    logic [REG_ADDR_W-1:0]   r_rd;
    logic [XLEN-1:0]         r_writedata;
    logic                    r_regwrite;
    logic [NUM_REGS-1:0]     r_busy;

    // Pop depends only on alu_valid and FIFO state, so ready (which allows
    // a push into a full FIFO that is popping) has no path from ll_valid.
    always_comb begin
        w_pop       = ~alu_valid & ~w_empty;
        ll_ready    = ~w_full | w_pop;
        w_push      = ll_valid & ll_ready;
        w_push_data = '{rd: ll_rd, data: ll_data};
    end

    result_fifo #(
        .DEPTH (DEPTH),
        .T     (ll_entry_t)
    ) u_result_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (fifo_count)
    );

    always_comb begin
        w_src      = SRC_NONE;
        w_sel_rd   = r_rd;
        w_sel_data = r_writedata;
        if (alu_valid) begin
            w_src      = SRC_ALU;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end else if (w_pop) begin
            w_src      = SRC_FIFO;
            w_sel_rd   = w_head.rd;
            w_sel_data = w_head.data;
        end
    end

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (iss_valid) begin
            w_set_mask = reg_mask(iss_rd);
        end
        if (w_src == SRC_FIFO) begin
            w_clr_mask = reg_mask(w_head.rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd        <= '0;
            r_writedata <= '0;
            r_regwrite  <= 1'b0;
        end else begin
            r_rd        <= w_sel_rd;
            r_writedata <= w_sel_data;
            r_regwrite  <= (w_src != SRC_NONE) && (w_sel_rd != '0);
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign rd        = r_rd;
    assign writedata = r_writedata;
    assign regwrite  = r_regwrite;
    assign busy      = r_busy;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH=4, XLEN=32).
module tb_regfile_writeback;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             ll_valid;
    logic             ll_ready;
    logic [4:0]       ll_rd;
    logic [XLEN-1:0]  ll_data;
    logic             iss_valid;
    logic [4:0]       iss_rd;
    logic [4:0]       rd;
    logic [XLEN-1:0]  writedata;
    logic             regwrite;
    logic [31:0]      busy;
    logic [2:0]       fifo_count;

    int checks = 0;
    int errors = 0;
    bit proto_en = 1'b1;

    always #5 clk = ~clk;

    regfile_writeback #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ll_valid   (ll_valid),
        .ll_ready   (ll_ready),
        .ll_rd      (ll_rd),
        .ll_data    (ll_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rd         (rd),
        .writedata  (writedata),
        .regwrite   (regwrite),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ll_valid  = 1'b0;
        iss_valid = 1'b0;
    endtask

    // Stimulus must respect the issue/result protocol the hazard unit guarantees.
    always @(posedge clk) begin
        if (rst_n && proto_en) begin
            if (iss_valid && iss_rd != 5'd0) begin
                checks++;
                assert (busy[iss_rd] === 1'b0) else begin
                    errors++;
                    $error("FAIL proto_issue_busy rd=%0d busy=0x%0h", iss_rd, busy);
                end
            end
            if (ll_valid) begin
                checks++;
                assert (busy[ll_rd] === 1'b1) else begin
                    errors++;
                    $error("FAIL proto_ll_not_busy rd=%0d busy=0x%0h", ll_rd, busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        alu_rd = '0; alu_data = '0; ll_rd = '0; ll_data = '0; iss_rd = '0;

        // Reset state
        #2;
        chk("rst_rd", rd, 0);
        chk("rst_wd", writedata, 0);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", ll_ready, 1);
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("post_rst_regwrite", regwrite, 0);

        // ALU only: one write the following cycle, then hold
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_rd", rd, 5);
        chk("alu_wd", writedata, 32'hDEADBEEF);
        chk("alu_regwrite", regwrite, 1);
        idle();
        step();
        chk("alu_regwrite_drop", regwrite, 0);
        chk("alu_rd_hold", rd, 5);
        chk("alu_wd_hold", writedata, 32'hDEADBEEF);

        // ALU write to x0
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        step();
        chk("x0_regwrite", regwrite, 0);
        idle();
        step();

        // Long-latency path
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        chk("ll_busy_set", busy, 32'h80);
        idle();
        step(); step(); step();
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
        step();
        chk("ll_accept_count", fifo_count, 1);
        chk("ll_accept_regwrite", regwrite, 0);
        chk("ll_accept_busy", busy, 32'h80);
        idle();
        step();
        chk("ll_wb_regwrite", regwrite, 1);
        chk("ll_wb_rd", rd, 7);
        chk("ll_wb_wd", writedata, 32'h1234);
        chk("ll_wb_busy", busy, 0);
        step();
        chk("ll_after_regwrite", regwrite, 0);
        chk("ll_after_count", fifo_count, 0);

        // Contention: ALU held 8 cycles while 5 results are offered
        for (int i = 0; i < 5; i++) begin
            iss_valid = 1'b1; iss_rd = 5'(10 + i);
            step();
        end
        idle();
        chk("cont_busy", busy, 32'h7C00);
        for (int k = 0; k < 8; k++) begin
            int e;
            e = (k < 4) ? k : 4;
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA000 + k;
            ll_valid  = 1'b1; ll_rd = 5'(10 + e); ll_data = 32'hB0 + e;
            step();
            chk("cont_alu_rd", rd, 3);
            chk("cont_alu_wd", writedata, 32'hA000 + k);
            chk("cont_alu_regwrite", regwrite, 1);
            chk("cont_count", fifo_count, (k + 1 < 4) ? k + 1 : 4);
            chk("cont_ready", ll_ready, (k + 1 < 4) ? 1 : 0);
        end
        // ALU idles with FIFO full: pop and push of the 5th entry together
        alu_valid = 1'b0;
        #1;
        chk("full_pop_ready", ll_ready, 1);
        step();
        chk("full_pp_rd", rd, 10);
        chk("full_pp_wd", writedata, 32'hB0);
        chk("full_pp_regwrite", regwrite, 1);
        chk("full_pp_count", fifo_count, 4);
        chk("full_pp_busy", busy, 32'h7800);
        ll_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            chk("drain_rd", rd, 10 + j);
            chk("drain_wd", writedata, 32'hB0 + j);
            chk("drain_regwrite", regwrite, 1);
            chk("drain_count", fifo_count, 4 - j);
            chk("drain_busy", busy, 32'h7C00 & ~((32'h1 << (11 + j)) - 32'h1));
        end
        step();
        chk("drain_idle_regwrite", regwrite, 0);

        // Collision: reissue rd=9 as the older rd=9 result pops
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        idle();
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
        step();
        chk("coll_count", fifo_count, 1);
        ll_valid = 1'b0;
        proto_en = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        proto_en = 1'b1;
        idle();
        chk("coll_regwrite", regwrite, 1);
        chk("coll_rd", rd, 9);
        chk("coll_wd", writedata, 32'h99);
        chk("coll_busy", busy, 32'h200);
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9A;
        step();
        idle();
        step();
        chk("coll2_rd", rd, 9);
        chk("coll2_wd", writedata, 32'h9A);
        chk("coll2_busy", busy, 0);

        // Reset mid-stream with 3 entries queued and busy=0x104
        iss_valid = 1'b1; iss_rd = 5'd2;
        step();
        iss_rd = 5'd8;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            ll_valid = 1'b1; ll_rd = (i == 1) ? 5'd8 : 5'd2; ll_data = 32'hC0 + i;
            step();
        end
        ll_valid = 1'b0;
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_busy", busy, 32'h104);
        chk("pre_rst_regwrite", regwrite, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_wd", writedata, 0);
        chk("mid_rst_regwrite", regwrite, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", fifo_count, 0);
        idle();
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rel_ready", ll_ready, 1);
        chk("rel_count", fifo_count, 0);
        step();
        chk("rel_regwrite_a", regwrite, 0);
        step();
        chk("rel_regwrite_b", regwrite, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
